lcd_pll_mgr: RTL

Runtime manager for the GW2A rPLL that generates the LCD pixel clock. It selects divider settings per display mode from a parametrised table and drives them onto the rPLL dynamic IDSEL/FBDSEL/ODSEL ports. It sequences PLL reset, qualifies LOCK with timeout and retry, and supervises lock during operation. It issues a clean reset to the LCD timing domain. It sits beside the rPLL instance and runs in the rPLL input-clock domain (27 MHz board clock).

---
 rtl/lcd_pll_mgr.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/lcd_pll_mgr.sv
// Runtime manager for the LCD pixel-clock rPLL: applies per-mode divider settings,
// sequences PLL reset, qualifies lock with timeout/retry and supervises lock while running.
module lcd_pll_mgr #(
  parameter int NUM_MODES = 4,
  parameter int MODE_W = 2,
  parameter logic [18*NUM_MODES-1:0] MODE_TABLE = {NUM_MODES{6'd3, 6'd24, 6'd4}},
  parameter int DEFAULT_MODE = 0,
  parameter int RST_CYCLES = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int MAX_RETRY = 3
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              mode_req,
  input  logic [MODE_W-1:0] mode_sel,
  output logic              mode_ack,
  output logic              mode_err,
  output logic              pll_rst,
  output logic [5:0]        idsel,
  output logic [5:0]        fbdsel,
  output logic [5:0]        odsel,
  output logic [MODE_W-1:0] cur_mode,
  output logic              busy,
  output logic              ready,
  output logic              fail,
  output logic              lcd_rst_n,
  output logic [7:0]        relock_cnt
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);
  localparam int ST_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W = $clog2(LOCK_TIMEOUT + 1);
  localparam int RT_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [RC_W-1:0]   RST_LAST  = RC_W'(RST_CYCLES - 1);
  localparam logic [ST_W-1:0]   STAB_LAST = ST_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [RT_W-1:0]   RT_MAX    = RT_W'(MAX_RETRY);
  localparam logic [MODE_W-1:0] DEF_MODE  = MODE_W'(DEFAULT_MODE);
  localparam logic [17:0]       DEF_SEL   = MODE_TABLE[18*DEFAULT_MODE +: 18];

  typedef enum logic [1:0] {S_APPLY, S_WAIT, S_READY, S_FAIL} state_t;

  state_t            state_q;
  logic [MODE_W-1:0] cur_mode_q;
  logic [17:0]       sel_q;
  logic              pll_rst_q, busy_q, ready_q, fail_q, lcd_rst_n_q;
  logic              mode_ack_q, mode_err_q;
  logic [7:0]        relock_q;
  logic [RT_W-1:0]   retry_q;
  logic [RC_W-1:0]   rst_cnt_q;
  logic [ST_W-1:0]   stab_q;
  logic [TO_W-1:0]   to_q;
  logic              lock_meta_q, lock_s_q;
  logic              req_ok;

  function automatic logic [17:0] entry(input logic [MODE_W-1:0] m);
    logic [17:0] e;
    e = MODE_TABLE[17:0];
    for (int i = 0; i < NUM_MODES; i++)
      if (m == MODE_W'(i)) e = MODE_TABLE[18*i +: 18];
    return e;
  endfunction

  assign req_ok = (32'(mode_sel) < NUM_MODES);

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_q     <= S_APPLY;
      cur_mode_q  <= DEF_MODE;
      sel_q       <= DEF_SEL;
      pll_rst_q   <= 1'b1;
      busy_q      <= 1'b1;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
      lcd_rst_n_q <= 1'b0;
      mode_ack_q  <= 1'b0;
      mode_err_q  <= 1'b0;
      relock_q    <= '0;
      retry_q     <= '0;
      rst_cnt_q   <= '0;
      stab_q      <= '0;
      to_q        <= '0;
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      lcd_rst_n_q <= ready_q;
      mode_ack_q  <= 1'b0;
      mode_err_q  <= 1'b0;
      case (state_q)
        S_APPLY: begin
          if (rst_cnt_q == RST_LAST) begin
            state_q   <= S_WAIT;
            pll_rst_q <= 1'b0;
            rst_cnt_q <= '0;
            to_q      <= '0;
            stab_q    <= '0;
          end else begin
            rst_cnt_q <= rst_cnt_q + RC_W'(1);
          end
        end
        S_WAIT: begin
          to_q   <= to_q + TO_W'(1);
          stab_q <= lock_s_q ? stab_q + ST_W'(1) : '0;
          // Stable-complete is checked first so it wins a tie with the timeout.
          if (lock_s_q && stab_q == STAB_LAST) begin
            state_q <= S_READY;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            retry_q <= '0;
          end else if (to_q == TO_LAST) begin
            if (retry_q < RT_MAX) begin
              retry_q   <= retry_q + RT_W'(1);
              state_q   <= S_APPLY;
              pll_rst_q <= 1'b1;
              rst_cnt_q <= '0;
            end else begin
              state_q <= S_FAIL;
              busy_q  <= 1'b0;
              fail_q  <= 1'b1;
            end
          end
        end
        S_READY, S_FAIL: begin
          if (mode_req) begin
            if (req_ok) begin
              mode_ack_q <= 1'b1;
              cur_mode_q <= mode_sel;
              sel_q      <= entry(mode_sel);
              retry_q    <= '0;
              state_q    <= S_APPLY;
              pll_rst_q  <= 1'b1;
              rst_cnt_q  <= '0;
              busy_q     <= 1'b1;
              ready_q    <= 1'b0;
              fail_q     <= 1'b0;
            end else begin
              mode_err_q <= 1'b1;
            end
          end else if (state_q == S_READY && !lock_s_q) begin
            // Lock lost while running: requalify without pulsing PLL reset.
            state_q <= S_WAIT;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            to_q    <= '0;
            stab_q  <= '0;
            retry_q <= '0;
            if (relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
          end
        end
        default: state_q <= S_APPLY;
      endcase
    end
  end

  assign mode_ack   = mode_ack_q;
  assign mode_err   = mode_err_q;
  assign pll_rst    = pll_rst_q;
  assign idsel      = sel_q[17:12];
  assign fbdsel     = sel_q[11:6];
  assign odsel      = sel_q[5:0];
  assign cur_mode   = cur_mode_q;
  assign busy       = busy_q;
  assign ready      = ready_q;
  assign fail       = fail_q;
  assign lcd_rst_n  = lcd_rst_n_q;
  assign relock_cnt = relock_q;

endmodule
